// File: rtl/mult_32_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mult_pkg;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned PROD_W    = 2 * WIDTH;
   localparam int unsigned MULT_ITER = WIDTH;
   localparam int unsigned CNT_W     = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Operand magnitude; 0x80000000 maps to itself and is read as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/mult_32_seq_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface mult_32_seq_if;
   import mult_pkg::*;

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, is_signed, a, b, input busy, done, hi, lo);
   modport slave  (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_32_seq_add.sv
// Combinational 32-bit adder with carry-out, counterpart of sub_32.
module add_32
   import mult_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum_c,
   output logic             carry_c
);

   assign {carry_c, sum_c} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_32_seq.sv
// Multi-cycle shift-and-add 32x32->64 multiplier for MIPS mult/multu.
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as the multiplier is exhausted.
module mult_32_seq
   import mult_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   mult_32_seq_if.slave bus
);

`ifdef MULT_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0]    mplr_q, mplr_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic [WIDTH-1:0]    lo_q, lo_d;

   logic [WIDTH-1:0]    addend_c;
   logic [WIDTH-1:0]    sum_c;
   logic                carry_c;
   logic [CNT_W-1:0]    shamt_c;
   logic [PROD_W-1:0]   prod_c;

   // Accumulate step: multiplicand into the upper accumulator half.
   assign addend_c = mplr_q[0] ? mcand_q : '0;

   add_32 u_add (
      .a       (acc_q[PROD_W-1:WIDTH]),
      .b       (addend_c),
      .sum_c   (sum_c),
      .carry_c (carry_c)
   );

   // Shifts still owed when the multiplier runs out early.
   assign shamt_c = CNT_W'(MULT_ITER) - cnt_q;
   assign prod_c  = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mcand_d = magnitude(bus.a, bus.is_signed);
               mplr_d  = magnitude(bus.b, bus.is_signed);
               neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (EARLY_EXIT && (mplr_q == '0)) begin
               acc_d   = acc_q >> shamt_c;
               state_d = ST_FIX;
            end else begin
               acc_d  = {carry_c, sum_c, acc_q[WIDTH-1:1]};
               mplr_d = mplr_q >> 1;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MULT_ITER - 1)) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            hi_d    = prod_c[PROD_W-1:WIDTH];
            lo_d    = prod_c[WIDTH-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_32_seq.sv
// Scoreboard bench for mult_32_seq: directed vectors, latency, ignored start, mid-op reset.
module tb_mult_32_seq;

`ifdef MULT_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [63:0] prod;
      int          edge_n;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mult_32_seq_if bus ();

   mult_32_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Edges from the start-sampling edge to the edge that raises done.
   function automatic int exp_lat(input logic sgn, input logic [31:0] b);
      logic [31:0] mb;
      int          k;
      mb = (sgn && b[31]) ? (~b + 32'd1) : b;
      k  = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
      return EE ? ((k < 32) ? k + 2 : 33) : 33;
   endfunction

   task automatic issue(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] prod);
      exp_t e;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.a         = a;
      bus.b         = b;
      e.name   = nm;
      e.prod   = prod;
      e.edge_n = cyc + 1;
      e.lat    = exp_lat(sgn, b);
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_vec(input string nm, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] prod);
      issue(nm, sgn, a, b, prod);
      wait_done();
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   initial begin
      exp_t e;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            check("done_pulse", 64'(prev_done), 64'd0);
            check("busy_at_done", 64'(bus.busy), 64'd0);
            if (sb.size() == 0) begin
               check("spurious_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check(e.name, {bus.hi, bus.lo}, e.prod);
               check({e.name, "_lat"}, 64'(cyc - e.edge_n), 64'(e.lat));
            end
         end
         prev_done = bus.done;
      end
   end

   initial begin
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_vec("s_max_x_m7",  1'b1, 32'h7fffffff, 32'hfffffff9, 64'hfffffffc_80000007);
      run_vec("u_f9_sq",     1'b0, 32'hfffffff9, 32'hfffffff9, 64'hfffffff2_00000031);
      run_vec("s_m7_sq",     1'b1, 32'hfffffff9, 32'hfffffff9, 64'h00000000_00000031);
      run_vec("s_min_x_9",   1'b1, 32'h80000000, 32'h00000009, 64'hfffffffb_80000000);
      run_vec("s_min_sq",    1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
      run_vec("s_a_x_4",     1'b1, 32'h0000000a, 32'h00000004, 64'h00000000_00000028);
      run_vec("u_b_zero",    1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000);
      run_vec("u_ones_sq",   1'b0, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001);
      run_vec("s_m1_sq",     1'b1, 32'hffffffff, 32'hffffffff, 64'h00000000_00000001);
      run_vec("s_m1_x_1",    1'b1, 32'hffffffff, 32'h00000001, 64'hffffffff_ffffffff);

      // Start pulses mid-operation with other operands must be ignored.
      issue("u_ignore", 1'b0, 32'h00000003, 32'h80000001, 64'h00000001_80000003);
      for (int i = 1; i <= 32; i++) begin
         check("busy_hold", 64'(bus.busy), 64'd1);
         if (i == 5 || i == 20) begin
            bus.start     = 1'b1;
            bus.is_signed = 1'b1;
            bus.a         = 32'h00000007;
            bus.b         = 32'h00000009;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      check("hilo_hold", {bus.hi, bus.lo}, 64'h00000001_80000003);

      // Reset in CALC cycle 10 discards the operation.
      issue("pre_rst", 1'b0, 32'hffffffff, 32'h80000000, 64'h7fffffff_80000000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      run_vec("post_rst", 1'b0, 32'hffffffff, 32'h80000000, 64'h7fffffff_80000000);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_32_seq.md
Name: mult_32_seq

Overview:
Multi-cycle 32x32 -> 64-bit shift-and-add multiplier. It provides MIPS mult/multu results to the HI/LO register path.
- It is the additive counterpart of the existing sub_32 datapath and is built around a 32-bit adder.
- It uses a start/busy/done handshake, so the control unit can stall or overlap issue while a product is computed.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = mult (two's complement), 0 = multu; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high from the edge after start is accepted until done is asserted
done  output  1  one-cycle pulse; hi/lo valid
hi  output  WIDTH  upper product half
lo  output  WIDTH  lower product half

Behaviour:
- One clock, clk. rst is synchronous and active-high: on any edge with rst=1, state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers are cleared. This applies mid-operation too; the partial result is discarded.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on start=1, latch operand magnitudes. If is_signed=1 and the MSB is set, use the two's-complement negation; otherwise the raw value. Latch neg = is_signed & (a[31]^b[31]). Clear the accumulator, count=0, busy=1, go to CALC. With start=0, stay in IDLE.
- Magnitude of 0x80000000 is 0x80000000, interpreted unsigned; no special case.
- CALC: one iteration per edge.
  - If the multiplier LSB is 1, add the multiplicand to the upper accumulator half via the adder; keep the 33-bit carry.
  - Shift {carry, acc} right 1. count++.
  - After the 32nd iteration (count==31 on that edge), go to FIX.
- FIX: if neg, the 64-bit product is two's-complement negated. Write hi/lo, done=1, busy=0, go to DONE.
- DONE: done=0, go to IDLE. Net latency is fixed: done is high in the 34th cycle after the edge sampling start. Back-to-back start is accepted in the cycle done is high is NOT allowed; start is accepted only from the cycle after.
- start while busy or in DONE is ignored; operands are not re-sampled.
- hi/lo hold their last result until the next FIX or rst. They never show partial values.
- Overflow cannot occur: the 64-bit result is exact for all inputs in both modes.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: in CALC, if the remaining shifted multiplier is zero, jump directly to FIX after aligning the accumulator. The alignment is a shift right by (32-count) in one cycle, so latency depends on the data. Minimum latency: done 3 cycles after start when b=0. The result is identical to the fixed-latency result.
- Undefined: always 32 CALC cycles; fixed latency as above.

Decomposition:
- Shared package/header mult_pkg:
  - State encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2, ST_DONE=2'd3.
  - MULT_ITER=WIDTH and the counter width (6 bits).
- Sub-module add_32: combinational 32-bit adder with carry-out, the counterpart of sub_32. It is instantiated once for the accumulate step.
- Final negation reuses inline ~x+1 on 64 bits.

Test Plan:
- Signed: is_signed=1, a=0x7fffffff, b=0xfffffff9 -> {hi,lo}=0xfffffffc_80000007; done pulses exactly one cycle, 34th cycle after start.
- Unsigned: is_signed=0, a=b=0xfffffff9 -> 0xfffffff2_00000031. Same a/b with is_signed=1 -> 0x00000000_00000031.
- Edge cases, signed:
  - a=0x80000000, b=0x9 -> 0xfffffffb_80000000.
  - a=b=0x80000000 -> 0x40000000_00000000.
  - a=0xa, b=0x4 -> 0x00000000_00000028.
- start pulsed again at cycles 5 and 20 of a busy operation with different operands -> ignored; result matches the first operands; busy stays high continuously.
- rst=1 at CALC cycle 10 -> next edge: busy=0, done=0, hi=lo=0. A fresh start after reset gives the correct product with full latency.
- With MULT_EARLY_EXIT_EN: b=0 -> product 0, done 3 cycles after start. a=0xa, b=0x4 -> 0x28 with latency < 34. All prior vectors give identical results.
